// File: rtl/mesm6_mem_responder.sv
// rtl/mesm6_mem_responder.sv - single-port SRAM responder arbitrating MESM-6 instruction and data buses
// Optional one-word fetch buffer: define MESM6_MEM_FETCH_BUF_EN.

module mesm6_mem_responder #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ibus_fetch,
    input  logic [14:0] ibus_addr,
    output logic [47:0] ibus_input,
    output logic        ibus_done,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [14:0] dbus_addr,
    input  logic [47:0] dbus_output,
    output logic [47:0] dbus_input,
    output logic        dbus_done,
    output logic [14:0] ram_addr,
    output logic        ram_en,
    output logic        ram_we,
    output logic [47:0] ram_wdata,
    input  logic [47:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_WRITE = 2'd2;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state, state_nx;
    logic [1:0]  kind_q;
    logic [14:0] addr_q;
    logic [47:0] wdata_q;
    logic [3:0]  cnt_q;
    logic        acc_d;
    logic [47:0] rdata_q;
    logic [47:0] ibus_q;
    logic [47:0] dbus_q;
    logic        dbus_req;
    logic        any_req;
    logic        hit;
    logic [47:0] rd_stage;
    logic [47:0] staged;

    assign dbus_req = dbus_read | dbus_write;
    assign any_req  = dbus_req | ibus_fetch;

    // Zero wait states: SRAM data arrives exactly in DONE, so use it directly.
    // Otherwise it was captured one cycle after ACCESS and held in rdata_q.
    assign rd_stage = (WAIT_STATES == 0) ? ram_rdata : rdata_q;

`ifdef MESM6_MEM_FETCH_BUF_EN
    logic [14:0] buf_addr;
    logic [47:0] buf_data;
    logic        buf_valid;
    logic        hit_q;

    // A fetch only hits when no data request takes priority this cycle.
    assign hit    = ibus_fetch && !dbus_req && buf_valid && (buf_addr == ibus_addr);
    assign staged = hit_q ? buf_data : rd_stage;

    // Fetch buffer: refilled by every SRAM fetch, dropped on a write to its word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_addr  <= 15'd0;
            buf_data  <= 48'd0;
            buf_valid <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                hit_q <= hit;
            end
            if (state == DONE && kind_q == K_FETCH && !hit_q) begin
                buf_addr  <= addr_q;
                buf_data  <= rd_stage;
                buf_valid <= 1'b1;
            end else if (state == DONE && kind_q == K_WRITE && addr_q == buf_addr) begin
                buf_valid <= 1'b0;
            end
        end
    end
`else
    assign hit    = 1'b0;
    assign staged = rd_stage;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and SRAM/done strobes decoded from the current state.
    always_comb begin
        state_nx  = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ibus_done = 1'b0;
        dbus_done = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = hit ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                ram_en   = 1'b1;
                ram_we   = (kind_q == K_WRITE);
                state_nx = (WS != 4'd0) ? WAIT : DONE;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                ibus_done = (kind_q == K_FETCH);
                dbus_done = (kind_q != K_FETCH);
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, wait counter and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind_q  <= K_FETCH;
            addr_q  <= 15'd0;
            wdata_q <= 48'd0;
            cnt_q   <= 4'd0;
            acc_d   <= 1'b0;
            rdata_q <= 48'd0;
        end else begin
            acc_d <= (state == ACCESS);
            if (acc_d) begin
                rdata_q <= ram_rdata;
            end
            case (state)
                IDLE: begin
                    if (dbus_req) begin
                        addr_q  <= dbus_addr;
                        wdata_q <= dbus_output;
                        kind_q  <= dbus_write ? K_WRITE : K_READ;
                    end else if (ibus_fetch) begin
                        addr_q <= ibus_addr;
                        kind_q <= K_FETCH;
                    end
                end
                ACCESS: begin
                    cnt_q <= (WS != 4'd0) ? (WS - 4'd1) : 4'd0;
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus read-data holding registers, updated as each access of their kind completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ibus_q <= 48'd0;
            dbus_q <= 48'd0;
        end else if (state == DONE) begin
            if (kind_q == K_FETCH) begin
                ibus_q <= staged;
            end else if (kind_q == K_READ) begin
                dbus_q <= staged;
            end
        end
    end

    assign ibus_input = (state == DONE && kind_q == K_FETCH) ? staged : ibus_q;
    assign dbus_input = (state == DONE && kind_q == K_READ) ? staged : dbus_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;

endmodule

// File: tb/tb_mesm6_mem_responder.sv
// tb/tb_mesm6_mem_responder.sv - scoreboard bench for mesm6_mem_responder (instances with 0 and 3 wait states)

module tb_mesm6_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ibus_fetch  [2];
    logic [14:0] ibus_addr   [2];
    logic [47:0] ibus_input  [2];
    logic        ibus_done   [2];
    logic        dbus_read   [2];
    logic        dbus_write  [2];
    logic [14:0] dbus_addr   [2];
    logic [47:0] dbus_output [2];
    logic [47:0] dbus_input  [2];
    logic        dbus_done   [2];
    logic [14:0] ram_addr    [2];
    logic        ram_en      [2];
    logic        ram_we      [2];
    logic [47:0] ram_wdata   [2];
    logic [47:0] ram_rdata   [2];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          coinc0 = 0;
    int          coinc1 = 0;
    logic [47:0] sb_q [$];
    logic [47:0] ref_mem [2][0:32767];
    logic [47:0] sram    [2][0:32767];
    logic [47:0] last_rd [2];
    logic [47:0] last_if [2];

    mesm6_mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .ibus_fetch(ibus_fetch[0]), .ibus_addr(ibus_addr[0]), .ibus_input(ibus_input[0]), .ibus_done(ibus_done[0]),
        .dbus_read(dbus_read[0]), .dbus_write(dbus_write[0]), .dbus_addr(dbus_addr[0]),
        .dbus_output(dbus_output[0]), .dbus_input(dbus_input[0]), .dbus_done(dbus_done[0]),
        .ram_addr(ram_addr[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    mesm6_mem_responder #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset),
        .ibus_fetch(ibus_fetch[1]), .ibus_addr(ibus_addr[1]), .ibus_input(ibus_input[1]), .ibus_done(ibus_done[1]),
        .dbus_read(dbus_read[1]), .dbus_write(dbus_write[1]), .dbus_addr(dbus_addr[1]),
        .dbus_output(dbus_output[1]), .dbus_input(dbus_input[1]), .dbus_done(dbus_done[1]),
        .ram_addr(ram_addr[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // Synchronous SRAMs, read data one cycle after ram_en.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ram_en[g]) begin
                if (ram_we[g]) sram[g][ram_addr[g]] <= ram_wdata[g];
                else           ram_rdata[g] <= sram[g][ram_addr[g]];
            end
        end
    end

    // Count cycles where both done pulses are high.
    always @(negedge clk) begin
        if (ibus_done[0] && dbus_done[0]) coinc0 <= coinc0 + 1;
        if (ibus_done[1] && dbus_done[1]) coinc1 <= coinc1 + 1;
    end

    function automatic int base_lat(input int k);
        return (k == 0) ? 2 : 5;
    endfunction

    // kind: 0 fetch, 1 read, 2 write, 3 read+write (acts as write)
    task automatic do_access(input int k, input int kind, input logic [14:0] addr, input logic [47:0] wd,
                             input int exp_lat, input int exp_en, input string name);
        int lat, en_cnt, we_cnt;
        logic [47:0] exp_d;
        bit is_rd;
        is_rd = (kind <= 1);
        @(negedge clk);
        if (kind == 0) begin
            ibus_fetch[k] = 1'b1;
            ibus_addr[k]  = addr;
        end else begin
            dbus_read[k]   = (kind == 1 || kind == 3);
            dbus_write[k]  = (kind >= 2);
            dbus_addr[k]   = addr;
            dbus_output[k] = wd;
        end
        if (is_rd) sb_q.push_back(ref_mem[k][addr]);
        else       ref_mem[k][addr] = wd;
        lat = -1; en_cnt = 0; we_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ram_en[k]) en_cnt++;
            if (ram_we[k]) we_cnt++;
            if ((kind == 0) ? ibus_done[k] : dbus_done[k]) begin
                lat = n;
                break;
            end
        end
        ibus_fetch[k] = 1'b0; dbus_read[k] = 1'b0; dbus_write[k] = 1'b0;
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++; $display("FAIL %s_latency dut%0d: got %0d expected %0d", name, k, lat, exp_lat);
        end
        if (lat >= 0) begin
            if (kind == 0) begin
                exp_d = sb_q.pop_front();
                n_cmp++;
                if (ibus_input[k] !== exp_d) begin
                    n_bad++; $display("FAIL %s_ibus_data dut%0d: got %o expected %o", name, k, ibus_input[k], exp_d);
                end
                last_if[k] = exp_d;
            end else if (kind == 1) begin
                exp_d = sb_q.pop_front();
                n_cmp++;
                if (dbus_input[k] !== exp_d) begin
                    n_bad++; $display("FAIL %s_dbus_data dut%0d: got %o expected %o", name, k, dbus_input[k], exp_d);
                end
                last_rd[k] = exp_d;
            end
            n_cmp++;
            if (kind == 0 ? (dbus_input[k] !== last_rd[k]) : (ibus_input[k] !== last_if[k])) begin
                n_bad++; $display("FAIL %s_other_hold dut%0d: ibus %o dbus %o expected ibus %o dbus %o",
                                  name, k, ibus_input[k], dbus_input[k], last_if[k], last_rd[k]);
            end
            if (kind >= 2) begin
                n_cmp++;
                if (dbus_input[k] !== last_rd[k]) begin
                    n_bad++; $display("FAIL %s_write_hold dut%0d: got %o expected %o", name, k, dbus_input[k], last_rd[k]);
                end
            end
        end else if (is_rd) begin
            sb_q.delete();
        end
        n_cmp++;
        if (en_cnt !== exp_en || we_cnt !== ((kind >= 2) ? 1 : 0)) begin
            n_bad++; $display("FAIL %s_ram_strobes dut%0d: en %0d we %0d expected en %0d we %0d",
                              name, k, en_cnt, we_cnt, exp_en, (kind >= 2) ? 1 : 0);
        end
        @(negedge clk);
        n_cmp++;
        if (ibus_done[k] !== 1'b0 || dbus_done[k] !== 1'b0) begin
            n_bad++; $display("FAIL %s_done_pulse dut%0d: ibus_done %b dbus_done %b expected 0 0", name, k, ibus_done[k], dbus_done[k]);
        end
        n_cmp++;
        if (ibus_input[k] !== last_if[k] || dbus_input[k] !== last_rd[k]) begin
            n_bad++; $display("FAIL %s_hold_after dut%0d: ibus %o dbus %o expected %o %o",
                              name, k, ibus_input[k], dbus_input[k], last_if[k], last_rd[k]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            ibus_fetch[g] = 1'b0; dbus_read[g] = 1'b0; dbus_write[g] = 1'b0;
            ibus_addr[g] = 15'd0; dbus_addr[g] = 15'd0; dbus_output[g] = 48'd0;
            last_rd[g] = 48'd0; last_if[g] = 48'd0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({ram_en[g], ram_we[g], ibus_done[g], dbus_done[g], ibus_input[g], dbus_input[g], ram_addr[g], ram_wdata[g]} !== '0) begin
                n_bad++; $display("FAIL reset_outputs dut%0d: en %b we %b id %b dd %b ii %o di %o ra %o rw %o expected all 0",
                                  g, ram_en[g], ram_we[g], ibus_done[g], dbus_done[g], ibus_input[g], dbus_input[g], ram_addr[g], ram_wdata[g]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_read_w0();
        do_access(0, 2, 15'o100, 48'o1234, 2, 1, "w0_write");
        do_access(0, 1, 15'o100, 48'd0, 2, 1, "w0_read");
    endtask

    task automatic test_write_read_w3();
        do_access(1, 2, 15'd5, 48'o7777, 5, 1, "w3_write");
        do_access(1, 1, 15'd5, 48'd0, 5, 1, "w3_read");
    endtask

    task automatic test_patterns();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++)
                do_access(k, 2, 15'(20 + i), {16'($urandom), $urandom}, base_lat(k), 1, "pat_write");
            for (int i = 0; i < 4; i++)
                do_access(k, 1, 15'(20 + i), 48'd0, base_lat(k), 1, "pat_read");
            for (int i = 0; i < 4; i++)
                do_access(k, 0, 15'(20 + i), 48'd0, base_lat(k), 1, "pat_fetch");
        end
    endtask

    task automatic test_both_rw();
        for (int k = 0; k < 2; k++) begin
            do_access(k, 3, 15'd30, 48'o525252525252, base_lat(k), 1, "rw_both");
            do_access(k, 1, 15'd30, 48'd0, base_lat(k), 1, "rw_check");
        end
    endtask

    task automatic test_arbitration();
        int d_lat, i_lat;
        logic [47:0] exp_d;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ibus_fetch[k] = 1'b1; ibus_addr[k] = 15'(20 + k);
            dbus_read[k]  = 1'b1; dbus_addr[k] = 15'd22;
            sb_q.push_back(ref_mem[k][22]);
            sb_q.push_back(ref_mem[k][20 + k]);
            d_lat = -1; i_lat = -1;
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk);
                if (dbus_done[k] && d_lat < 0) begin
                    d_lat = n; dbus_read[k] = 1'b0;
                    if (sb_q.size() > 0) begin
                        exp_d = sb_q.pop_front();
                        n_cmp++;
                        if (dbus_input[k] !== exp_d) begin
                            n_bad++; $display("FAIL arb_dbus_data dut%0d: got %o expected %o", k, dbus_input[k], exp_d);
                        end
                        last_rd[k] = exp_d;
                    end
                end
                if (ibus_done[k] && i_lat < 0) begin
                    i_lat = n; ibus_fetch[k] = 1'b0;
                    if (sb_q.size() > 0) begin
                        exp_d = sb_q.pop_front();
                        n_cmp++;
                        if (ibus_input[k] !== exp_d) begin
                            n_bad++; $display("FAIL arb_ibus_data dut%0d: got %o expected %o", k, ibus_input[k], exp_d);
                        end
                        last_if[k] = exp_d;
                    end
                end
                if (d_lat >= 0 && i_lat >= 0) break;
            end
            ibus_fetch[k] = 1'b0; dbus_read[k] = 1'b0;
            sb_q.delete();
            n_cmp++;
            if (d_lat !== base_lat(k) || i_lat !== 2 * base_lat(k) + 1) begin
                n_bad++; $display("FAIL arb_latency dut%0d: dbus %0d ibus %0d expected %0d %0d",
                                  k, d_lat, i_lat, base_lat(k), 2 * base_lat(k) + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [47:0] exp_d;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            dbus_read[k] = 1'b1; dbus_addr[k] = 15'd21;
            sb_q.push_back(ref_mem[k][21]);
            sb_q.push_back(ref_mem[k][21]);
            d1 = -1; d2 = -1;
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk);
                if (dbus_done[k]) begin
                    if (sb_q.size() > 0) begin
                        exp_d = sb_q.pop_front();
                        n_cmp++;
                        if (dbus_input[k] !== exp_d) begin
                            n_bad++; $display("FAIL b2b_data dut%0d: got %o expected %o", k, dbus_input[k], exp_d);
                        end
                        last_rd[k] = exp_d;
                    end
                    if (d1 < 0) d1 = n;
                    else begin
                        d2 = n; dbus_read[k] = 1'b0;
                        break;
                    end
                end
            end
            dbus_read[k] = 1'b0;
            sb_q.delete();
            n_cmp++;
            if (d1 !== base_lat(k) || d2 !== 2 * base_lat(k) + 1) begin
                n_bad++; $display("FAIL b2b_latency dut%0d: got %0d %0d expected %0d %0d", k, d1, d2, base_lat(k), 2 * base_lat(k) + 1);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_abort_deassert();
        int lat;
        logic [47:0] exp_d;
        @(negedge clk);
        dbus_read[1] = 1'b1; dbus_addr[1] = 15'd23;
        sb_q.push_back(ref_mem[1][23]);
        @(negedge clk);
        dbus_read[1] = 1'b0;
        lat = -1;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (dbus_done[1]) begin
                lat = n;
                break;
            end
        end
        exp_d = sb_q.pop_front();
        n_cmp++;
        if (lat !== 5) begin
            n_bad++; $display("FAIL abort_latency dut1: got %0d expected 5", lat);
        end
        n_cmp++;
        if (dbus_input[1] !== exp_d) begin
            n_bad++; $display("FAIL abort_data dut1: got %o expected %o", dbus_input[1], exp_d);
        end
        last_rd[1] = exp_d;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        dbus_read[1] = 1'b1; dbus_addr[1] = 15'd5; dbus_output[1] = 48'o5555;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dbus_read[1] = 1'b0;
        #1;
        n_cmp++;
        if ({ram_en[1], ram_we[1], ibus_done[1], dbus_done[1], ibus_input[1], dbus_input[1], ram_addr[1], ram_wdata[1]} !== '0) begin
            n_bad++; $display("FAIL reset_mid_outputs dut1: en %b we %b id %b dd %b ii %o di %o ra %o rw %o expected all 0",
                              ram_en[1], ram_we[1], ibus_done[1], dbus_done[1], ibus_input[1], dbus_input[1], ram_addr[1], ram_wdata[1]);
        end
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 3) reset = 1'b1;
            if (ibus_done[1] || dbus_done[1]) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++; $display("FAIL reset_mid_no_done dut1: got %0d done pulses expected 0", dones);
        end
        for (int g = 0; g < 2; g++) begin
            last_rd[g] = 48'd0; last_if[g] = 48'd0;
        end
        do_access(1, 0, 15'd5, 48'd0, 5, 1, "reset_mid_fetch");
    endtask

    task automatic test_fetch_buf();
        for (int k = 0; k < 2; k++) begin
            do_access(k, 2, 15'd7, 48'o111122223333, base_lat(k), 1, "fb_init");
            do_access(k, 0, 15'd7, 48'd0, base_lat(k), 1, "fb_first");
`ifdef MESM6_MEM_FETCH_BUF_EN
            do_access(k, 0, 15'd7, 48'd0, 1, 0, "fb_hit");
`else
            do_access(k, 0, 15'd7, 48'd0, base_lat(k), 1, "fb_second");
`endif
            do_access(k, 2, 15'd7, 48'o444455556666, base_lat(k), 1, "fb_write");
            do_access(k, 0, 15'd7, 48'd0, base_lat(k), 1, "fb_refetch");
        end
    endtask

    initial begin
        test_reset();
        test_read_w0();
        test_write_read_w3();
        test_patterns();
        test_both_rw();
        test_arbitration();
        test_back_to_back();
        test_abort_deassert();
        test_reset_mid();
        test_fetch_buf();
        @(negedge clk);
        n_cmp++;
        if (coinc0 !== 0 || coinc1 !== 0) begin
            n_bad++; $display("FAIL done_coincident: dut0 %0d dut1 %0d cycles expected 0 0", coinc0, coinc1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mesm6_mem_responder.md
MESM6_MEM_RESPONDER -- requirements
Module: mesm6_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, range 0-15: extra SRAM cycles per access.
REQ-002 SHALL have ports:
  clk          in   1   clock, rising edge
  reset        in   1   asynchronous, active-low reset
  ibus_fetch   in   1   instruction fetch request, level, held until done
  ibus_addr    in   15  fetch word address
  ibus_input   out  48  fetched instruction word
  ibus_done    out  1   fetch complete, one-cycle pulse
  dbus_read    in   1   data read request, level
  dbus_write   in   1   data write request, level
  dbus_addr    in   15  data word address
  dbus_output  in   48  write data from core
  dbus_input   out  48  read data to core
  dbus_done    out  1   data access complete, one-cycle pulse
  ram_addr     out  15  SRAM address
  ram_en       out  1   SRAM cycle enable
  ram_we       out  1   SRAM write enable, valid with ram_en
  ram_wdata    out  48  SRAM write data
  ram_rdata    in   48  SRAM read data, valid one cycle after ram_en

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE.
REQ-004 IDLE: at each clk edge SHALL sample requests; on any request SHALL latch address, write data and kind (ifetch/read/write), then go to ACCESS.
REQ-005 Arbitration: dbus request SHALL win over a simultaneous ibus_fetch; the ibus request stays pending and SHALL be served next.
REQ-006 When dbus_read and dbus_write are both high, the access SHALL be a write.
REQ-007 ACCESS: ram_en=1, ram_addr=latched address, ram_we=1 for write, ram_wdata=latched data; exactly one cycle.
REQ-008 WAIT: entered only if WAIT_STATES>0; SHALL last WAIT_STATES cycles with a 4-bit down-counter; ram_en=0.
REQ-009 DONE: SHALL assert exactly one done pulse (ibus_done for fetch, dbus_done for read/write) and return to IDLE.
REQ-010 For reads, ibus_input/dbus_input SHALL be registered from ram_rdata on the cycle after ACCESS and valid in the DONE cycle.
REQ-011 ibus_input and dbus_input SHALL hold their last value until the next completed access of the same kind; writes do not change dbus_input.
REQ-012 Latency: a request first high in cycle 0 from IDLE SHALL see done in cycle 2+WAIT_STATES.
REQ-013 A request still high in the cycle after DONE SHALL be treated as a new access (back-to-back micro-ops).
REQ-014 Requests deasserted before done SHALL NOT abort an access already in ACCESS/WAIT; the access completes and the done pulse is still issued.
REQ-015 ibus_done and dbus_done SHALL never be high in the same cycle.

Reset
REQ-016 While reset=0: state=IDLE, ram_en=0, ram_we=0, ibus_done=0, dbus_done=0, ibus_input=0, dbus_input=0, ram_addr=0, ram_wdata=0, wait counter=0, fetch buffer invalid.
REQ-017 Reset asserted mid-access SHALL abandon the access immediately with no done pulse; first request after release is served per REQ-004.

Configuration
REQ-018 Macro MESM6_MEM_FETCH_BUF_EN: when defined, SHALL keep a one-word fetch buffer (address, data, valid); ibus_fetch whose address matches a valid buffer SHALL skip ACCESS/WAIT and get ibus_done in cycle 1 with buffered data; every fetch from SRAM SHALL refill it; a dbus write to the buffered address SHALL invalidate it.
REQ-019 Without MESM6_MEM_FETCH_BUF_EN, no buffer logic SHALL exist; every fetch takes REQ-012 latency.

Verification
REQ-020 WAIT_STATES=0, SRAM[0o100]=0o1234, dbus_read addr 0o100 at cycle 0 -> dbus_done high cycle 2 only, dbus_input=0o1234.
REQ-021 WAIT_STATES=3, dbus_write addr 5 data 0o7777 then dbus_read addr 5 -> write done cycle 5; read returns 0o7777, ram_we high exactly one cycle.
REQ-022 ibus_fetch and dbus_read both rise cycle 0 -> dbus_done cycle 2, ibus_done cycle 5 (WAIT_STATES=0), never coincident.
REQ-023 reset pulled low during WAIT -> no done pulse, all outputs 0; next fetch after release completes with normal latency.
REQ-024 MESM6_MEM_FETCH_BUF_EN defined: fetch addr 7 twice -> second ibus_done in cycle 1 with no ram_en; after dbus_write to 7, third fetch takes full latency and returns new data.
